// File: rtl/pie_tx_encoder_pkg.sv
// Shared definitions for the PIE transmit encoder: FSM encoding and symbol unit counts.
package pie_tx_encoder_pkg;

    localparam int PTS_W  = 12;
    localparam int UNIT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELIM = 3'd1,
        ST_DATA0 = 3'd2,
        ST_RTCAL = 3'd3,
        ST_TRCAL = 3'd4,
        ST_DATA  = 3'd5,
        ST_TAIL  = 3'd6
    } tx_state_e;

    localparam logic [UNIT_W-1:0] SYM_D0    = 3'd1;
    localparam logic [UNIT_W-1:0] SYM_D1    = 3'd2;
    localparam logic [UNIT_W-1:0] SYM_RTCAL = 3'd3;

    function automatic logic [UNIT_W-1:0] data_units(input logic b);
        return b ? SYM_D1 : SYM_D0;
    endfunction

endpackage

// File: rtl/pie_tx_encoder_symbol_gen.sv
// One PIE symbol: length n_units*tari_pts points, high then low for the final pw_pts points.
module pie_symbol_gen
    import pie_tx_encoder_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic              run_i,
    input  logic [UNIT_W-1:0] n_units_i,
    input  logic [PTS_W-1:0]  tari_pts_i,
    input  logic [PTS_W-1:0]  pw_pts_i,
    output logic              level_o,
    output logic              sym_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic             level_q, level_d;

    // level_q is the envelope of the point cnt_d, so the output is registered
    // and the first point of a symbol appears on the cycle after start_i.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        pw_d  = pw_q;
        if (start_i) begin
            len_d = CNT_W'(n_units_i) * CNT_W'(tari_pts_i);
            pw_d  = CNT_W'(pw_pts_i);
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        level_d = (start_i || run_i) ? (cnt_d < len_d - pw_d) : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n || clr_i) begin
            cnt_q   <= '0;
            len_q   <= '0;
            pw_q    <= '0;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pw_q    <= pw_d;
            level_q <= level_d;
        end
    end

    assign level_o   = level_q;
    assign sym_end_o = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/pie_tx_encoder.sv
// PIE reader-to-tag transmit encoder: delimiter, data-0, RTcal, optional TRcal, data, CW tail.
module pie_tx_encoder
    import pie_tx_encoder_pkg::*;
#(
    parameter int TRCAL_UNITS = 6,
    parameter int TAIL_PTS    = 64,
    parameter int CNT_W       = 15
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             tx_enable,
    input  logic             frame_start,
    input  logic             preamble_sel,
    input  logic [PTS_W-1:0] tari_pts,
    input  logic [PTS_W-1:0] pw_pts,
    input  logic [PTS_W-1:0] delim_pts,
    input  logic             bit_valid,
    input  logic             bit_data,
    input  logic             bit_last,
    output logic             bit_ready,
    output logic             tx_mod,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);

    tx_state_e        state_q, state_d;
    logic [PTS_W-1:0] tari_q, tari_d, pw_q, pw_d;
    logic             pre_q, pre_d;
    logic             hold_full_q, hold_full_d, hold_data_q, hold_data_d;
    logic             last_taken_q, last_taken_d;
    logic             busy_q, err_q, err_d, done_q, done_d;

    logic              g_start, g_run, g_level, g_end;
    logic [UNIT_W-1:0] g_units;
    logic [PTS_W-1:0]  g_tari, g_pw;
    logic              accept, load, cfg_ok;

    assign bit_ready = busy_q & ~hold_full_q & ~last_taken_q;
    assign accept    = bit_valid & bit_ready;
    assign cfg_ok    = (pw_pts != '0) && (pw_pts < tari_pts) && (delim_pts != '0);

    always_comb begin
        state_d = state_q;
        tari_d  = tari_q;
        pw_d    = pw_q;
        pre_d   = pre_q;
        g_start = 1'b0;
        g_units = SYM_D0;
        g_tari  = tari_q;
        g_pw    = pw_q;
        load    = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    if (cfg_ok) begin
                        // Delimiter is a one-unit symbol whose low window covers all of it.
                        state_d = ST_DELIM;
                        g_start = 1'b1;
                        g_tari  = delim_pts;
                        g_pw    = delim_pts;
                        tari_d  = tari_pts;
                        pw_d    = pw_pts;
                        pre_d   = preamble_sel;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DELIM: if (g_end) begin
                state_d = ST_DATA0;
                g_start = 1'b1;
                g_units = SYM_D0;
            end
            ST_DATA0: if (g_end) begin
                state_d = ST_RTCAL;
                g_start = 1'b1;
                g_units = SYM_RTCAL;
            end
            ST_RTCAL, ST_TRCAL, ST_DATA: if (g_end) begin
                g_start = 1'b1;
                if (state_q == ST_RTCAL && pre_q) begin
                    state_d = ST_TRCAL;
                    g_units = UNIT_W'(TRCAL_UNITS);
                end else if (hold_full_q) begin
                    state_d = ST_DATA;
                    load    = 1'b1;
                    g_units = data_units(hold_data_q);
                end else begin
                    // Tail is an all-high symbol; missing data here is an underrun.
                    state_d = ST_TAIL;
                    g_tari  = PTS_W'(TAIL_PTS);
                    g_pw    = '0;
                    err_d   = ~last_taken_q;
                end
            end
            ST_TAIL: if (g_end) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        g_run        = (state_d != ST_IDLE);
        hold_full_d  = g_run & (accept | (hold_full_q & ~load));
        hold_data_d  = accept ? bit_data : hold_data_q;
        last_taken_d = g_run & (last_taken_q | (accept & bit_last));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n || !tx_enable) begin
            state_q      <= ST_IDLE;
            tari_q       <= '0;
            pw_q         <= '0;
            pre_q        <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 1'b0;
            last_taken_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tari_q       <= tari_d;
            pw_q         <= pw_d;
            pre_q        <= pre_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            last_taken_q <= last_taken_d;
            busy_q       <= (state_d != ST_IDLE);
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    pie_symbol_gen #(.CNT_W(CNT_W)) u_sym (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .clr_i      (~tx_enable),
        .start_i    (g_start),
        .run_i      (g_run),
        .n_units_i  (g_units),
        .tari_pts_i (g_tari),
        .pw_pts_i   (g_pw),
        .level_o    (g_level),
        .sym_end_o  (g_end)
    );

    assign tx_mod  = g_level;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_pie_tx_encoder.sv
// Scoreboard bench: a frame model builds the expected per-cycle envelope, a monitor compares it.
module tb_pie_tx_encoder;

    localparam int TAIL = 64;
    localparam int TRC  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, tx_enable = 1'b0, frame_start = 1'b0, preamble_sel = 1'b0;
    logic [11:0] tari_pts = '0, pw_pts = '0, delim_pts = '0;
    logic        bit_valid = 1'b0, bit_data = 1'b0, bit_last = 1'b0;
    logic        bit_ready, tx_mod, tx_busy, tx_done, tx_err;

    always #5 clk = ~clk;

    pie_tx_encoder #(.TRCAL_UNITS(TRC), .TAIL_PTS(TAIL), .CNT_W(15)) dut (
        .clk_i(clk), .rst_n(rst_n), .tx_enable(tx_enable), .frame_start(frame_start),
        .preamble_sel(preamble_sel), .tari_pts(tari_pts), .pw_pts(pw_pts), .delim_pts(delim_pts),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last), .bit_ready(bit_ready),
        .tx_mod(tx_mod), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    typedef struct packed { logic mod; logic busy; logic err; logic done; } exp_t;
    exp_t sb[$];
    exp_t fq[$];
    int   checks = 0, errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---- reference model: one entry per sampled cycle, starting with the cycle frame_start is driven
    task automatic emit(input logic m, input logic b, input logic e, input logic d);
        exp_t x;
        x.mod = m; x.busy = b; x.err = e; x.done = d;
        fq.push_back(x);
    endtask

    task automatic emit_sym(input int n, input int tari, input int pw);
        for (int i = 0; i < n * tari; i++) emit(i < n * tari - pw, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_frame(input bit pre, input int tari, input int pw, input int delim,
                               input logic [31:0] bits, input int nbits, input bit has_last);
        fq.delete();
        emit(1'b1, 1'b0, 1'b0, 1'b0);
        if (pw == 0 || pw >= tari || delim == 0) begin
            emit(1'b1, 1'b0, 1'b1, 1'b0);
            emit(1'b1, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int i = 0; i < delim; i++) emit(1'b0, 1'b1, 1'b0, 1'b0);
        emit_sym(1, tari, pw);
        emit_sym(3, tari, pw);
        if (pre) emit_sym(TRC, tari, pw);
        for (int b = 0; b < nbits; b++) emit_sym(bits[b] ? 2 : 1, tari, pw);
        for (int i = 0; i < TAIL; i++) emit(1'b1, 1'b1, (i == 0) && !has_last, 1'b0);
        emit(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // ---- monitor
    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                check("tx_mod", tx_mod, m_e.mod);
                check("tx_busy", tx_busy, m_e.busy);
                check("tx_err", tx_err, m_e.err);
                check("tx_done", tx_done, m_e.done);
            end else begin
                check("idle tx_mod", tx_mod, 1'b1);
                check("idle tx_busy", tx_busy, 1'b0);
                check("idle tx_err", tx_err, 1'b0);
                check("idle tx_done", tx_done, 1'b0);
            end
        end
    end

    // ---- stimulus
    task automatic drive_bits(input logic [31:0] bits, input int nbits, input bit has_last);
        int w;
        for (int b = 0; b < nbits; b++) begin
            bit_valid = 1'b1;
            bit_data  = bits[b];
            bit_last  = has_last && (b == nbits - 1);
            w = 0;
            @(negedge clk);
            while (!bit_ready && w < 500) begin w++; @(negedge clk); end
            if (!bit_ready) fail("bit accept");
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        if (has_last)
            repeat (3) begin @(negedge clk); check("bit_ready after last", bit_ready, 1'b0); end
    endtask

    // Mid-frame input changes (and an optional frame_start) must not disturb the frame.
    task automatic scramble(input bit pulse);
        repeat (3) @(posedge clk);
        #1;
        tari_pts     = 12'($urandom);
        pw_pts       = 12'($urandom);
        delim_pts    = 12'($urandom);
        preamble_sel = 1'($urandom);
        if (pulse) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 5000) begin @(negedge clk); w++; end
        if (sb.size() > 0) begin fail("frame drain"); sb.delete(); end
        @(posedge clk);
    endtask

    task automatic run_frame(input bit pre, input int tari, input int pw, input int delim,
                             input logic [31:0] bits, input int nbits, input bit has_last,
                             input bit pulse);
        bit ok;
        ok = (pw > 0) && (pw < tari) && (delim > 0);
        @(posedge clk); #1;
        model_frame(pre, tari, pw, delim, bits, nbits, has_last);
        foreach (fq[i]) sb.push_back(fq[i]);
        preamble_sel = pre;
        tari_pts     = 12'(tari);
        pw_pts       = 12'(pw);
        delim_pts    = 12'(delim);
        frame_start  = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (ok) fork
            drive_bits(bits, nbits, has_last);
            scramble(pulse);
        join
        wait_drain();
    endtask

    // Abort a few points into RTcal; only the prefix up to the abort is expected.
    task automatic run_abort();
        int a;
        a = 10 + 8 + 2;
        @(posedge clk); #1;
        model_frame(1'b1, 8, 4, 10, 32'h0, 0, 1'b1);
        for (int i = 0; i < a + 2; i++) sb.push_back(fq[i]);
        preamble_sel = 1'b1;
        tari_pts     = 12'd8;
        pw_pts       = 12'd4;
        delim_pts    = 12'd10;
        frame_start  = 1'b1;
        bit_valid    = 1'b1;
        bit_data     = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (a) @(posedge clk);
        #1;
        tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_enable = 1'b1;
        bit_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx_mod", tx_mod, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);
        check("reset bit_ready", bit_ready, 1'b0);
        check("reset tx_err", tx_err, 1'b0);
        check("reset tx_done", tx_done, 1'b0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_frame(1'b0, 8, 4, 10, 32'h2, 2, 1'b1, 1'b0);   // frame-sync, bits 0,1
        run_frame(1'b1, 8, 4, 10, 32'h2, 2, 1'b1, 1'b0);   // preamble with TRcal
        run_frame(1'b0, 8, 4, 10, 32'h0, 1, 1'b0, 1'b0);   // underrun after bit 0
        run_frame(1'b0, 8, 8, 10, 32'h0, 0, 1'b1, 1'b0);   // pw == tari
        run_frame(1'b0, 8, 0, 10, 32'h0, 0, 1'b1, 1'b0);   // pw == 0
        run_frame(1'b0, 8, 4, 0,  32'h0, 0, 1'b1, 1'b0);   // delim == 0
        run_abort();
        run_frame(1'b0, 8, 4, 10, 32'h5, 3, 1'b1, 1'b0);   // clean restart
        run_frame(1'b0, 8, 4, 10, 32'h16, 5, 1'b1, 1'b1);  // back-to-back, ignored frame_start
        run_frame(1'b1, 2, 1, 1,  32'h1B, 5, 1'b1, 1'b1);  // shortest legal symbols
        run_frame(1'b1, 8, 4, 10, 32'h0, 0, 1'b0, 1'b0);   // underrun straight after TRcal

        for (int k = 0; k < 12; k++) begin
            int t, p, d, n;
            bit hl;
            logic [31:0] bb;
            t  = int'($urandom_range(16, 2));
            p  = int'($urandom_range(t - 1, 1));
            d  = int'($urandom_range(16, 1));
            if ($urandom_range(5, 0) == 0) p = t + int'($urandom_range(2, 0));
            n  = int'($urandom_range(5, 0));
            hl = ($urandom_range(3, 0) != 0);
            if (hl && n == 0) n = 1;
            bb = $urandom;
            run_frame(1'($urandom), t, p, d, bb, n, hl, 1'($urandom));
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
